// File: rtl/risc_control_fsm_v2.sv
`default_nettype none
// ============================================================================
//  Module      : risc_control_fsm_v2
//  Description : Moore control FSM for the Simple RISC Machine. Sequences
//                fetch, decode, ALU, immediate move, LDR/STR and optional
//                HALT, with a bounded-wait memory handshake and a sticky
//                fault state.
//  Options     : CTRL_HALT_EN - when defined, opcode 111 enters a sticky
//                HALT state; otherwise opcode 111 faults and halted is 0.
//  Revision    : 2.0 - parametrised memory timeout, fault and halt states
// ============================================================================
module risc_control_fsm_v2 #(
    parameter int MEM_TO = 16,  // cycles a memory command may wait (>= 1)
    parameter int TO_W   = 5    // wait counter width, 2**TO_W > MEM_TO
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic       mem_ready,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic [2:0] nsel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] mem_cmd,
    output logic       w,
    output logic       halted,
    output logic       fault
);

    // State encoding. ST_ALUMV is the ALU pass with A forced to zero used
    // by MOV-register and MVN; ST_ALU is the normal two-operand pass.
    typedef enum logic [4:0] {
        ST_RST    = 5'd0,
        ST_WAIT   = 5'd1,
        ST_FETCH  = 5'd2,
        ST_LOADIR = 5'd3,
        ST_DECODE = 5'd4,
        ST_MOVIM  = 5'd5,
        ST_GETA   = 5'd6,
        ST_GETB   = 5'd7,
        ST_ALU    = 5'd8,
        ST_ALUMV  = 5'd9,
        ST_STATUS = 5'd10,
        ST_WRRD   = 5'd11,
        ST_ADDR   = 5'd12,
        ST_LDADDR = 5'd13,
        ST_MEMRD  = 5'd14,
        ST_WRMEM  = 5'd15,
        ST_GETRD  = 5'd16,
        ST_PASSB  = 5'd17,
        ST_MEMWR  = 5'd18,
        ST_HALT   = 5'd19,
        ST_FAULT  = 5'd20
    } state_t;

    // Instruction encodings as {opcode, op}
    localparam logic [4:0] c_ins_movim = 5'b110_10;
    localparam logic [4:0] c_ins_movrg = 5'b110_00;
    localparam logic [4:0] c_ins_mvn   = 5'b101_11;
    localparam logic [4:0] c_ins_add   = 5'b101_00;
    localparam logic [4:0] c_ins_cmp   = 5'b101_01;
    localparam logic [4:0] c_ins_and   = 5'b101_10;
    localparam logic [4:0] c_ins_ldr   = 5'b011_00;
    localparam logic [4:0] c_ins_str   = 5'b100_00;

    // Counter value on the last permitted wait cycle of a memory command
    localparam logic [TO_W-1:0] c_to_last = TO_W'(MEM_TO - 1);
    localparam logic [TO_W-1:0] c_cnt_one = TO_W'(1);

    localparam logic [1:0] c_mem_none  = 2'b00;
    localparam logic [1:0] c_mem_read  = 2'b01;
    localparam logic [1:0] c_mem_write = 2'b10;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TO_W-1:0] r_cnt;
    logic [TO_W-1:0] w_cnt_nxt;

    logic [4:0]      w_ins;
    logic            w_is_mov;
    logic            w_is_cmp;
    logic            w_is_ldst;
    logic            w_is_str;
    logic            w_to_last;

    // Instruction classification used by the multi-path states
    always_comb begin
        w_ins     = {opcode, op};
        w_is_mov  = (w_ins == c_ins_movrg) || (w_ins == c_ins_mvn);
        w_is_cmp  = (w_ins == c_ins_cmp);
        w_is_str  = (w_ins == c_ins_str);
        w_is_ldst = (w_ins == c_ins_ldr) || w_is_str;
        w_to_last = (r_cnt == c_to_last);
    end

    // State and wait-counter registers; reset wins from any state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic. The counter only survives while a memory command
    // keeps waiting; every other path clears it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_RST:    w_state_nxt = ST_WAIT;
            ST_WAIT:   if (s) w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)      w_state_nxt = ST_LOADIR;
                else if (w_to_last) w_state_nxt = ST_FAULT;
                else                w_cnt_nxt   = r_cnt + c_cnt_one;
            end
            ST_LOADIR: w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (w_ins)
                    c_ins_movim:              w_state_nxt = ST_MOVIM;
                    c_ins_movrg, c_ins_mvn:   w_state_nxt = ST_GETB;
                    c_ins_add, c_ins_and,
                    c_ins_cmp:                w_state_nxt = ST_GETA;
                    c_ins_ldr, c_ins_str:     w_state_nxt = ST_GETA;
                    default: begin
`ifdef CTRL_HALT_EN
                        if (opcode == 3'b111) w_state_nxt = ST_HALT;
                        else                  w_state_nxt = ST_FAULT;
`else
                        w_state_nxt = ST_FAULT;
`endif
                    end
                endcase
            end
            ST_MOVIM:  w_state_nxt = ST_WAIT;
            ST_GETA:   w_state_nxt = w_is_ldst ? ST_ADDR : ST_GETB;
            ST_GETB: begin
                if (w_is_mov)      w_state_nxt = ST_ALUMV;
                else if (w_is_cmp) w_state_nxt = ST_STATUS;
                else               w_state_nxt = ST_ALU;
            end
            ST_ALU:    w_state_nxt = ST_WRRD;
            ST_ALUMV:  w_state_nxt = ST_WRRD;
            ST_STATUS: w_state_nxt = ST_WAIT;
            ST_WRRD:   w_state_nxt = ST_WAIT;
            ST_ADDR:   w_state_nxt = ST_LDADDR;
            ST_LDADDR: w_state_nxt = w_is_str ? ST_GETRD : ST_MEMRD;
            ST_MEMRD: begin
                if (mem_ready)      w_state_nxt = ST_WRMEM;
                else if (w_to_last) w_state_nxt = ST_FAULT;
                else                w_cnt_nxt   = r_cnt + c_cnt_one;
            end
            ST_WRMEM:  w_state_nxt = ST_WAIT;
            ST_GETRD:  w_state_nxt = ST_PASSB;
            ST_PASSB:  w_state_nxt = ST_MEMWR;
            ST_MEMWR: begin
                if (mem_ready)      w_state_nxt = ST_WAIT;
                else if (w_to_last) w_state_nxt = ST_FAULT;
                else                w_cnt_nxt   = r_cnt + c_cnt_one;
            end
            ST_HALT:   w_state_nxt = ST_HALT;
            ST_FAULT:  w_state_nxt = ST_FAULT;
            default:   w_state_nxt = ST_FAULT;
        endcase
    end

    // Moore output decode: every output is a function of r_state only
    always_comb begin
        vsel      = 2'b00;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        nsel      = 3'b000;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = c_mem_none;
        w         = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (r_state)
            ST_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            ST_WAIT:   w = 1'b1;
            ST_FETCH: begin
                addr_sel = 1'b1;
                mem_cmd  = c_mem_read;
            end
            ST_LOADIR: begin
                load_ir = 1'b1;
                load_pc = 1'b1;
            end
            ST_MOVIM: begin
                nsel  = 3'b100;
                vsel  = 2'b10;
                write = 1'b1;
            end
            ST_GETA: begin
                nsel  = 3'b100;
                loada = 1'b1;
            end
            ST_GETB: begin
                nsel  = 3'b001;
                loadb = 1'b1;
            end
            ST_ALU:    loadc = 1'b1;
            ST_ALUMV: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            ST_STATUS: loads = 1'b1;
            ST_WRRD: begin
                nsel  = 3'b010;
                vsel  = 2'b00;
                write = 1'b1;
            end
            ST_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            ST_LDADDR: load_addr = 1'b1;
            ST_MEMRD: begin
                mem_cmd  = c_mem_read;
                addr_sel = 1'b0;
            end
            ST_WRMEM: begin
                nsel  = 3'b010;
                vsel  = 2'b11;
                write = 1'b1;
            end
            ST_GETRD: begin
                nsel  = 3'b010;
                loadb = 1'b1;
            end
            ST_PASSB: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            ST_MEMWR:  mem_cmd = c_mem_write;
`ifdef CTRL_HALT_EN
            ST_HALT:   halted = 1'b1;
`endif
            ST_FAULT:  fault = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire
